// File: rtl/ob_cntrl_mk_commit.sv
// ob_cntrl_mk_commit: sequences one market-order match: query, capture decision, issue queue commands, emit trade.
package bcd_pkg;
  typedef logic [15:0] price_t;
endpackage

package ob_pkg;
  typedef logic [31:0] uid_t;
  typedef logic [15:0] quantity_t;
  typedef struct packed {
    logic             mk_ask_lm_bid;
    logic             lm_ask_mk_bid;
    logic             mk_ask_mk_bid;
    logic             ask_consumed;
    logic             bid_consumed;
    uid_t             ask_uid;
    uid_t             bid_uid;
    bcd_pkg::price_t  ask_price;
    quantity_t        quantity;
    quantity_t        remainder;
  } cntrl_mk_t;
endpackage

module ob_cntrl_mk_commit #(
  parameter int CNT_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  output logic                trade_qry,
  input  logic                trade_vld_r,
  input  ob_pkg::cntrl_mk_t   trade_r,
  output logic                mk_buy_pop,
  output logic                mk_sell_pop,
  output logic                lm_bid_pop,
  output logic                lm_ask_pop,
  output logic                mk_buy_upd,
  output logic                mk_sell_upd,
  output logic                lm_bid_upd,
  output logic                lm_ask_upd,
  output ob_pkg::quantity_t   upd_quantity,
  input  logic                cmd_ack,
  output logic                out_vld_r,
  input  logic                out_accept,
  output ob_pkg::uid_t        out_ask_uid_r,
  output ob_pkg::uid_t        out_bid_uid_r,
  output bcd_pkg::price_t     out_price_r,
  output ob_pkg::quantity_t   out_quantity_r,
  output logic                err_r,
  output logic                busy_r,
  output logic [CNT_W-1:0]    trade_cnt_r
);
  typedef enum logic [2:0] {IDLE, QRY, WAIT, CMD, EMIT} state_t;
  state_t            state;
  logic [3:0]        pop_r, upd_r;
  ob_pkg::uid_t      cap_ask_uid, cap_bid_uid;
  bcd_pkg::price_t   cap_price;
  ob_pkg::quantity_t cap_quantity;
  logic              bad, ask_mk, bid_lm, ask_upd, bid_upd;
  logic [3:0]        pop_n, upd_n;
  assign {mk_buy_pop, mk_sell_pop, lm_bid_pop, lm_ask_pop} = pop_r;
  assign {mk_buy_upd, mk_sell_upd, lm_bid_upd, lm_ask_upd} = upd_r;
  assign busy_r = state != IDLE;
  // Decode the live decision; only consulted in WAIT when trade_vld_r is high.
  always_comb begin
    bad     = !$onehot({trade_r.mk_ask_lm_bid, trade_r.lm_ask_mk_bid, trade_r.mk_ask_mk_bid}) ||
              (!trade_r.ask_consumed && !trade_r.bid_consumed && trade_r.remainder == '0);
    ask_mk  = trade_r.mk_ask_lm_bid | trade_r.mk_ask_mk_bid;
    bid_lm  = trade_r.mk_ask_lm_bid;
    ask_upd = !trade_r.ask_consumed;
    bid_upd = trade_r.ask_consumed & !trade_r.bid_consumed;
    pop_n   = {!bid_lm & trade_r.bid_consumed, ask_mk & trade_r.ask_consumed,
               bid_lm & trade_r.bid_consumed, !ask_mk & trade_r.ask_consumed};
    upd_n   = {!bid_lm & bid_upd, ask_mk & ask_upd, bid_lm & bid_upd, !ask_mk & ask_upd};
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      trade_qry      <= 1'b0;
      err_r          <= 1'b0;
      pop_r          <= '0;
      upd_r          <= '0;
      upd_quantity   <= '0;
      out_vld_r      <= 1'b0;
      out_ask_uid_r  <= '0;
      out_bid_uid_r  <= '0;
      out_price_r    <= '0;
      out_quantity_r <= '0;
      trade_cnt_r    <= '0;
      cap_ask_uid    <= '0;
      cap_bid_uid    <= '0;
      cap_price      <= '0;
      cap_quantity   <= '0;
    end else begin
      trade_qry <= 1'b0;
      err_r     <= 1'b0;
      case (state)
        IDLE: if (en) begin
          state     <= QRY;
          trade_qry <= 1'b1;
        end
        QRY: state <= WAIT;
        WAIT: if (!trade_vld_r) begin
          state <= IDLE;
        end else begin
          cap_ask_uid  <= trade_r.ask_uid;
          cap_bid_uid  <= trade_r.bid_uid;
          cap_price    <= trade_r.ask_price;
          cap_quantity <= trade_r.quantity;
          state        <= bad ? IDLE : CMD;
          err_r        <= bad;
          pop_r        <= bad ? '0 : pop_n;
          upd_r        <= bad ? '0 : upd_n;
          upd_quantity <= bad ? '0 : trade_r.remainder;
        end
        CMD: if (cmd_ack) begin
          state          <= EMIT;
          pop_r          <= '0;
          upd_r          <= '0;
          upd_quantity   <= '0;
          out_vld_r      <= 1'b1;
          out_ask_uid_r  <= cap_ask_uid;
          out_bid_uid_r  <= cap_bid_uid;
          out_price_r    <= cap_price;
          out_quantity_r <= cap_quantity;
        end
        EMIT: if (out_accept) begin
          state       <= IDLE;
          out_vld_r   <= 1'b0;
          trade_cnt_r <= trade_cnt_r + CNT_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ob_cntrl_mk_commit.sv
// tb_ob_cntrl_mk_commit: directed bench for the market-order commit sequencer.
module tb_ob_cntrl_mk_commit;
  import ob_pkg::*;
  logic clk = 1'b0, rst = 1'b0, en = 1'b0, trade_vld_r = 1'b0, cmd_ack = 1'b0, out_accept = 1'b0;
  cntrl_mk_t trade_r = '0;
  logic trade_qry, mk_buy_pop, mk_sell_pop, lm_bid_pop, lm_ask_pop;
  logic mk_buy_upd, mk_sell_upd, lm_bid_upd, lm_ask_upd, out_vld_r, err_r, busy_r;
  quantity_t upd_quantity, out_quantity_r;
  uid_t out_ask_uid_r, out_bid_uid_r;
  bcd_pkg::price_t out_price_r;
  logic [1:0] trade_cnt_r;
  int checks = 0, errors = 0;
  ob_cntrl_mk_commit #(.CNT_W(2)) dut (
    .clk(clk), .rst(rst), .en(en), .trade_qry(trade_qry), .trade_vld_r(trade_vld_r), .trade_r(trade_r),
    .mk_buy_pop(mk_buy_pop), .mk_sell_pop(mk_sell_pop), .lm_bid_pop(lm_bid_pop), .lm_ask_pop(lm_ask_pop),
    .mk_buy_upd(mk_buy_upd), .mk_sell_upd(mk_sell_upd), .lm_bid_upd(lm_bid_upd), .lm_ask_upd(lm_ask_upd),
    .upd_quantity(upd_quantity), .cmd_ack(cmd_ack), .out_vld_r(out_vld_r), .out_accept(out_accept),
    .out_ask_uid_r(out_ask_uid_r), .out_bid_uid_r(out_bid_uid_r), .out_price_r(out_price_r),
    .out_quantity_r(out_quantity_r), .err_r(err_r), .busy_r(busy_r), .trade_cnt_r(trade_cnt_r)
  );
  always #5 clk = ~clk;
  wire [3:0] pops = {mk_buy_pop, mk_sell_pop, lm_bid_pop, lm_ask_pop};
  wire [3:0] upds = {mk_buy_upd, mk_sell_upd, lm_bid_upd, lm_ask_upd};
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic cntrl_mk_t mk(input logic [2:0] k, input logic ac, input logic bc,
                                   input logic [15:0] qty, input logic [15:0] rem);
    cntrl_mk_t d;
    d = '0;
    {d.mk_ask_lm_bid, d.lm_ask_mk_bid, d.mk_ask_mk_bid} = k;
    d.ask_consumed = ac;
    d.bid_consumed = bc;
    d.ask_uid      = 32'h100 + 32'(qty);
    d.bid_uid      = 32'h200 + 32'(qty);
    d.ask_price    = 16'h1234;
    d.quantity     = qty;
    d.remainder    = rem;
    return d;
  endfunction
  task automatic run_to_cmd(input cntrl_mk_t d);
    en = 1'b1;
    @(negedge clk);
    chk("qry_pulse", trade_qry, 1'b1);
    en = 1'b0;
    @(negedge clk);
    chk("qry_one_cycle", trade_qry, 1'b0);
    trade_vld_r = 1'b1;
    trade_r = d;
    @(negedge clk);
    trade_vld_r = 1'b0;
    trade_r = '1;
  endtask
  task automatic ack_and_accept(input logic [15:0] qty, input logic [1:0] cnt);
    cmd_ack = 1'b1;
    @(negedge clk);
    cmd_ack = 1'b0;
    chk("emit_vld", out_vld_r, 1'b1);
    chk("emit_qty", out_quantity_r, qty);
    chk("emit_pops_clear", {pops, upds}, 8'h00);
    out_accept = 1'b1;
    @(negedge clk);
    out_accept = 1'b0;
    chk("accept_vld_low", out_vld_r, 1'b0);
    chk("accept_cnt", trade_cnt_r, cnt);
    chk("accept_idle", busy_r, 1'b0);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_outs", {trade_qry, pops, upds, out_vld_r, err_r, busy_r}, 16'h0);
    chk("rst_data", {upd_quantity, out_quantity_r, out_ask_uid_r, trade_cnt_r}, 64'h0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_no_en", busy_r, 1'b0);
    // mk_ask_lm_bid, ask consumed, bid updated to 3; ack two cycles late
    run_to_cmd(mk(3'b100, 1'b1, 1'b0, 16'd5, 16'd3));
    chk("t1_pops", pops, 4'b0100);
    chk("t1_upds", upds, 4'b0010);
    chk("t1_upd_qty", upd_quantity, 16'd3);
    @(negedge clk);
    chk("t1_hold_pops", pops, 4'b0100);
    chk("t1_hold_upds", upds, 4'b0010);
    chk("t1_no_vld", out_vld_r, 1'b0);
    @(negedge clk);
    ack_and_accept(16'd5, 2'd1);
    chk("t1_ask_uid", out_ask_uid_r, 32'h105);
    chk("t1_bid_uid", out_bid_uid_r, 32'h205);
    chk("t1_price", out_price_r, 16'h1234);
    // lm_ask_mk_bid, both consumed; ack in first CMD cycle gives 4-cycle latency
    run_to_cmd(mk(3'b010, 1'b1, 1'b1, 16'd7, 16'd0));
    chk("t2_pops", pops, 4'b1001);
    chk("t2_upds", upds, 4'b0000);
    chk("t2_vld_not_yet", out_vld_r, 1'b0);
    ack_and_accept(16'd7, 2'd2);
    // no trade: back to IDLE two cycles after QRY, reissued while en held
    en = 1'b1;
    @(negedge clk);
    chk("t3_qry", trade_qry, 1'b1);
    @(negedge clk);
    chk("t3_wait_busy", busy_r, 1'b1);
    chk("t3_wait_qry", trade_qry, 1'b0);
    @(negedge clk);
    chk("t3_idle", busy_r, 1'b0);
    chk("t3_no_cmd", {pops, upds, out_vld_r, err_r}, 10'h0);
    @(negedge clk);
    chk("t3_requery", trade_qry, 1'b1);
    en = 1'b0;
    repeat (2) @(negedge clk);
    chk("t3_idle2", busy_r, 1'b0);
    // malformed kind flags
    run_to_cmd(mk(3'b110, 1'b1, 1'b0, 16'd9, 16'd1));
    chk("t4_err", err_r, 1'b1);
    chk("t4_no_cmd", {pops, upds}, 8'h00);
    chk("t4_idle", busy_r, 1'b0);
    @(negedge clk);
    chk("t4_err_pulse", err_r, 1'b0);
    chk("t4_cnt", trade_cnt_r, 2'd2);
    // both sides partial: only ask side updated
    run_to_cmd(mk(3'b001, 1'b0, 1'b0, 16'd6, 16'd4));
    chk("t5_pops", pops, 4'b0000);
    chk("t5_upds", upds, 4'b0100);
    chk("t5_upd_qty", upd_quantity, 16'd4);
    ack_and_accept(16'd6, 2'd3);
    // stalled accept, then counter wrap
    run_to_cmd(mk(3'b100, 1'b1, 1'b1, 16'd8, 16'd0));
    cmd_ack = 1'b1;
    en = 1'b1;
    @(negedge clk);
    cmd_ack = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("t6_hold_vld", out_vld_r, 1'b1);
      chk("t6_hold_data", {out_quantity_r, out_ask_uid_r[15:0], out_price_r}, {16'd8, 16'h108, 16'h1234});
      chk("t6_no_qry", trade_qry, 1'b0);
      @(negedge clk);
    end
    out_accept = 1'b1;
    en = 1'b0;
    @(negedge clk);
    out_accept = 1'b0;
    chk("t6_wrap", trade_cnt_r, 2'd0);
    chk("t6_vld_low", out_vld_r, 1'b0);
    // reset during CMD
    run_to_cmd(mk(3'b010, 1'b0, 1'b1, 16'd3, 16'd2));
    chk("t7_pre_rst_upds", upds, 4'b0001);
    rst = 1'b0;
    #1;
    chk("t7_rst_outs", {trade_qry, pops, upds, out_vld_r, err_r, busy_r}, 16'h0);
    chk("t7_rst_data", {upd_quantity, out_quantity_r, out_bid_uid_r, trade_cnt_r}, 64'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t7_idle", busy_r, 1'b0);
    run_to_cmd(mk(3'b100, 1'b1, 1'b1, 16'd9, 16'd0));
    chk("t7_pops", pops, 4'b0110);
    chk("t7_upds", upds, 4'b0000);
    ack_and_accept(16'd9, 2'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
